// File: rtl/sprite_anim_rom_if.sv
// Request/result bundle between the sprite renderer and sprite_anim_rom.
// The master drives lookups and animation control; the slave returns pixel results.
interface sprite_anim_rom_if #(
  parameter int unsigned FB       = 2,
  parameter int unsigned IDX_BITS = 3
);

  logic                frame_tick;
  logic                anim_en;
  logic                restart;
  logic [FB-1:0]       base_frame;
  logic [FB:0]         seq_len;
  logic                req_valid;
  logic [9:0]          draw_x;
  logic [9:0]          draw_y;
  logic [9:0]          pos_x;
  logic [9:0]          pos_y;
  logic                flip_h;
  logic                out_valid;
  logic [IDX_BITS-1:0] out_index;
  logic                out_opaque;
  logic [FB-1:0]       cur_frame;

  modport master (
    output frame_tick, anim_en, restart, base_frame, seq_len,
    output req_valid, draw_x, draw_y, pos_x, pos_y, flip_h,
    input  out_valid, out_index, out_opaque, cur_frame
  );

  modport slave (
    input  frame_tick, anim_en, restart, base_frame, seq_len,
    input  req_valid, draw_x, draw_y, pos_x, pos_y, flip_h,
    output out_valid, out_index, out_opaque, cur_frame
  );

endinterface

// File: rtl/sprite_anim_rom.sv
// Multi-frame sprite ROM: animation sequencing on frame ticks, bounding-box hit test,
// optional horizontal mirror, and a two-stage lookup pipeline (result two cycles after request).
module sprite_anim_rom #(
  parameter int unsigned FRAMES          = 4,
  parameter int unsigned SPR_W           = 32,
  parameter int unsigned SPR_H           = 32,
  parameter int unsigned IDX_BITS        = 3,
  parameter int unsigned TRANSP_IDX      = 0,
  parameter int unsigned TICKS_PER_FRAME = 8,
  parameter string       INIT_FILE       = "sprite.mif"
) (
  input logic              clock,
  input logic              reset,
  sprite_anim_rom_if.slave bus
);

  localparam int unsigned FB    = $clog2(FRAMES);
  localparam int unsigned XB    = $clog2(SPR_W);
  localparam int unsigned YB    = $clog2(SPR_H);
  localparam int unsigned AW    = FB + YB + XB;
  localparam int unsigned DEPTH = FRAMES * SPR_W * SPR_H;
  localparam int unsigned TW    = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int unsigned LW    = FB + 1;

  // Parameter sanity: the address packing relies on power-of-two dimensions.
  if (FRAMES < 2 || (FRAMES & (FRAMES - 1)) != 0) begin : g_bad_frames
    $error("sprite_anim_rom: FRAMES must be a power of two >= 2");
  end
  if (SPR_W < 2 || SPR_W > 512 || (SPR_W & (SPR_W - 1)) != 0) begin : g_bad_w
    $error("sprite_anim_rom: SPR_W must be a power of two in 2..512");
  end
  if (SPR_H < 2 || SPR_H > 512 || (SPR_H & (SPR_H - 1)) != 0) begin : g_bad_h
    $error("sprite_anim_rom: SPR_H must be a power of two in 2..512");
  end
  if (TICKS_PER_FRAME < 1) begin : g_bad_ticks
    $error("sprite_anim_rom: TICKS_PER_FRAME must be >= 1");
  end

  // Animation counters
  logic [TW-1:0] tick_q, tick_d;
  logic [FB-1:0] ofs_q, ofs_d;
  logic [LW-1:0] len_eff_c;
  logic [LW-1:0] ofs_inc_c;
  logic [FB-1:0] frame_c;

  // Lookup datapath
  logic [10:0]   dx_c, dy_c, px_c, py_c;
  logic          hit_c;
  logic [XB-1:0] ox_c;
  logic [YB-1:0] oy_c;
  logic [AW-1:0] addr_c;

  // Pipeline registers
  logic                va_q, va_d;
  logic                hit_a_q, hit_a_d;
  logic [AW-1:0]       addr_a_q, addr_a_d;
  logic                vb_q, vb_d;
  logic                hit_b_q, hit_b_d;
  logic [IDX_BITS-1:0] q_b_q;
  logic                opaque_c;

  // Next animation state: restart beats anim_en, which gates frame_tick.
  always_comb begin
    tick_d    = tick_q;
    ofs_d     = ofs_q;
    len_eff_c = (bus.seq_len == '0) ? LW'(1) : bus.seq_len;
    ofs_inc_c = LW'(ofs_q) + LW'(1);
    if (bus.restart) begin
      tick_d = '0;
      ofs_d  = '0;
    end else if (bus.anim_en && bus.frame_tick) begin
      if (tick_q == TW'(TICKS_PER_FRAME - 1)) begin
        tick_d = '0;
        // >= so a shrunken sequence length snaps back to the first frame
        ofs_d  = (ofs_inc_c >= len_eff_c) ? '0 : FB'(ofs_inc_c);
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // FRAMES is a power of two, so FB-bit addition wraps modulo FRAMES.
  assign frame_c       = bus.base_frame + ofs_q;
  assign bus.cur_frame = frame_c;

  // Box test in 11 bits so pos + size never wraps past the 10-bit screen range.
  always_comb begin
    dx_c   = {1'b0, bus.draw_x};
    dy_c   = {1'b0, bus.draw_y};
    px_c   = {1'b0, bus.pos_x};
    py_c   = {1'b0, bus.pos_y};
    hit_c  = (dx_c >= px_c) && (dx_c < px_c + 11'(SPR_W)) &&
             (dy_c >= py_c) && (dy_c < py_c + 11'(SPR_H));
    ox_c   = XB'(bus.draw_x - bus.pos_x);
    oy_c   = YB'(bus.draw_y - bus.pos_y);
    if (bus.flip_h) begin
      ox_c = ~ox_c;
    end
    addr_c = {frame_c, oy_c, ox_c};
  end

  // Stage A samples the frame; stage B carries valid/hit beside the ROM read.
  always_comb begin
    va_d     = bus.req_valid;
    hit_a_d  = hit_c;
    addr_a_d = addr_c;
    vb_d     = va_q;
    hit_b_d  = hit_a_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q   <= '0;
      ofs_q    <= '0;
      va_q     <= 1'b0;
      hit_a_q  <= 1'b0;
      addr_a_q <= '0;
      vb_q     <= 1'b0;
      hit_b_q  <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      ofs_q    <= ofs_d;
      va_q     <= va_d;
      hit_a_q  <= hit_a_d;
      addr_a_q <= addr_a_d;
      vb_q     <= vb_d;
      hit_b_q  <= hit_b_d;
    end
  end

  // Built-in deterministic test image used when no init file is given.
  function automatic logic [IDX_BITS-1:0] test_word(input logic [AW-1:0] a);
    int unsigned f, y, x;
    f = 32'(a[AW-1 -: FB]);
    y = 32'(a[XB +: YB]);
    x = 32'(a[XB-1:0]);
    return IDX_BITS'(3 * f + y + x + 1);
  endfunction

  // Read port is unreset so it maps onto block RAM; results are masked by vb_q.
  if (INIT_FILE == "") begin : g_test_image
    always_ff @(posedge clock) begin
      q_b_q <= test_word(addr_a_q);
    end
  end else begin : g_file_image
    (* ram_init_file = INIT_FILE *) logic [IDX_BITS-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
      q_b_q <= mem[addr_a_q];
    end
  end

  assign opaque_c       = vb_q & hit_b_q & (q_b_q != IDX_BITS'(TRANSP_IDX));
  assign bus.out_opaque = opaque_c;
  assign bus.out_index  = opaque_c ? q_b_q : '0;
  assign bus.out_valid  = vb_q;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Directed bench for sprite_anim_rom: box edges, mirroring, animation sequencing,
// restart/seq_len corner cases, a 64-request stream across a frame change, and mid-stream reset.
module tb_sprite_anim_rom;

  localparam int unsigned FB       = 2;
  localparam int unsigned IDX_BITS = 3;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  sprite_anim_rom_if #(.FB(FB), .IDX_BITS(IDX_BITS)) bus ();

  sprite_anim_rom #(.INIT_FILE("")) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Contents of the built-in test image: (3*frame + oy + ox + 1) mod 8.
  function automatic int unsigned rom_word(input int unsigned f, input int unsigned y,
                                           input int unsigned x);
    return (3 * f + y + x + 1) % 8;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    bus.frame_tick = 1'b1;
    repeat (n) step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
  endtask

  task automatic lookup(input string tag, input int unsigned x, input int unsigned y,
                        input logic flip, input int unsigned exp_opq, input int unsigned exp_idx);
    bus.req_valid = 1'b1;
    bus.draw_x    = 10'(x);
    bus.draw_y    = 10'(y);
    bus.flip_h    = flip;
    step();
    bus.req_valid = 1'b0;
    step();
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_opq"}, 32'(bus.out_opaque), exp_opq);
    check_eq({tag, "_idx"}, 32'(bus.out_index), exp_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned run;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.anim_en    = 1'b0;
    bus.restart    = 1'b0;
    bus.base_frame = 2'd1;
    bus.seq_len    = 3'd3;
    bus.req_valid  = 1'b0;
    bus.draw_x     = '0;
    bus.draw_y     = '0;
    bus.pos_x      = 10'd100;
    bus.pos_y      = 10'd50;
    bus.flip_h     = 1'b0;

    #2;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_opq", 32'(bus.out_opaque), 32'd0);
    check_eq("rst_idx", 32'(bus.out_index), 32'd0);
    check_eq("rst_frame", 32'(bus.cur_frame), 32'd1);
    step();
    step();
    reset = 1'b0;
    step();

    // Box edges, frame 1, pos=(100,50)
    lookup("box_x100", 100, 50, 1'b0, 1, 4);
    lookup("box_x131", 131, 50, 1'b0, 1, 3);
    lookup("box_x132", 132, 50, 1'b0, 0, 0);
    lookup("box_x99", 99, 50, 1'b0, 0, 0);
    lookup("box_y82", 100, 82, 1'b0, 0, 0);
    lookup("box_y81", 100, 81, 1'b0, 1, 3);
    lookup("flip_ox0", 100, 50, 1'b1, 1, 3);
    lookup("transp", 104, 50, 1'b0, 0, 0);
    lookup("flip_transp", 127, 50, 1'b1, 0, 0);

    // Animation: base 1, length 3, 8 ticks per step
    bus.anim_en = 1'b1;
    pulse_restart();
    ticks(7);  check_eq("anim_t7", 32'(bus.cur_frame), 32'd1);
    ticks(1);  check_eq("anim_t8", 32'(bus.cur_frame), 32'd2);
    ticks(8);  check_eq("anim_t16", 32'(bus.cur_frame), 32'd3);
    ticks(8);  check_eq("anim_t24", 32'(bus.cur_frame), 32'd1);
    bus.anim_en = 1'b0;
    ticks(20); check_eq("hold_20", 32'(bus.cur_frame), 32'd1);
    bus.anim_en = 1'b1;
    ticks(7);  check_eq("hold_resume7", 32'(bus.cur_frame), 32'd1);
    ticks(1);  check_eq("hold_resume8", 32'(bus.cur_frame), 32'd2);

    // Restart on the same cycle as the wrapping tick
    ticks(7);  check_eq("rs_pre", 32'(bus.cur_frame), 32'd2);
    bus.frame_tick = 1'b1;
    bus.restart    = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.restart    = 1'b0;
    check_eq("rs_frame", 32'(bus.cur_frame), 32'd1);
    ticks(7);  check_eq("rs_tick7", 32'(bus.cur_frame), 32'd1);
    ticks(1);  check_eq("rs_tick8", 32'(bus.cur_frame), 32'd2);

    // Shrink seq_len below the current offset
    ticks(8);  check_eq("shrink_pre", 32'(bus.cur_frame), 32'd3);
    bus.seq_len = 3'd1;
    step();    check_eq("shrink_hold", 32'(bus.cur_frame), 32'd3);
    ticks(8);  check_eq("shrink_wrap", 32'(bus.cur_frame), 32'd1);

    // seq_len = 0 behaves as a single frame
    bus.seq_len = 3'd0;
    pulse_restart();
    ticks(16); check_eq("len0", 32'(bus.cur_frame), 32'd1);

    // base + offset wraps modulo FRAMES
    bus.base_frame = 2'd3;
    bus.seq_len    = 3'd3;
    pulse_restart();
    check_eq("wrap_ofs0", 32'(bus.cur_frame), 32'd3);
    ticks(8);  check_eq("wrap_ofs1", 32'(bus.cur_frame), 32'd0);
    ticks(8);  check_eq("wrap_ofs2", 32'(bus.cur_frame), 32'd1);
    ticks(8);  check_eq("wrap_ofs3", 32'(bus.cur_frame), 32'd3);

    // 64 back-to-back requests; frame 0 -> 1 on the tick issued with request 20
    bus.base_frame = 2'd0;
    bus.seq_len    = 3'd4;
    bus.pos_x      = 10'd0;
    bus.pos_y      = 10'd0;
    pulse_restart();
    ticks(7);
    run = 0;
    for (int i = 0; i < 66; i++) begin
      if (i >= 2) begin
        int unsigned k, x, y, f, ox, idx, opq;
        logic        fl;
        k   = i - 2;
        x   = k;
        y   = k % 7;
        fl  = (k % 3 == 0);
        f   = (k <= 20) ? 0 : 1;
        ox  = fl ? 31 - (x % 32) : (x % 32);
        idx = rom_word(f, y, ox);
        opq = (x < 32 && idx != 0) ? 1 : 0;
        check_eq($sformatf("b2b_valid%0d", k), 32'(bus.out_valid), 32'd1);
        check_eq($sformatf("b2b_opq%0d", k), 32'(bus.out_opaque), opq);
        check_eq($sformatf("b2b_idx%0d", k), 32'(bus.out_index), opq != 0 ? idx : 0);
        if (bus.out_valid === 1'b1) run++;
      end
      if (i < 64) begin
        bus.req_valid = 1'b1;
        bus.draw_x    = 10'(i);
        bus.draw_y    = 10'(i % 7);
        bus.flip_h    = (i % 3 == 0);
      end else begin
        bus.req_valid = 1'b0;
      end
      bus.frame_tick = (i == 20);
      step();
    end
    bus.frame_tick = 1'b0;
    check_eq("b2b_run", run, 32'd64);
    check_eq("b2b_frame", 32'(bus.cur_frame), 32'd1);

    // Asynchronous reset in the middle of a continuous stream
    bus.req_valid = 1'b1;
    bus.draw_x    = 10'd5;
    bus.draw_y    = 10'd5;
    bus.flip_h    = 1'b0;
    step();
    step();
    check_eq("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_opq", 32'(bus.out_opaque), 32'd0);
    check_eq("mid_rst_idx", 32'(bus.out_index), 32'd0);
    check_eq("mid_rst_frame", 32'(bus.cur_frame), 32'd0);
    step();
    reset = 1'b0;
    check_eq("post_rst0", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("post_rst1", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("post_rst2_valid", 32'(bus.out_valid), 32'd1);
    check_eq("post_rst2_opq", 32'(bus.out_opaque), 32'd1);
    check_eq("post_rst2_idx", 32'(bus.out_index), 32'd3);
    bus.req_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
